// File: rtl/uart_pkg.sv
// uart_pkg: types and default constants shared by the UART receiver, transmitter and baud generator
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous input, reset value selectable
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] r_sync;

   // shift the async input through two flops; the second one is safe to use
   always_ff @(posedge i_clk)
      if (i_reset) r_sync <= {2{RST_VAL}};
      else r_sync <= {r_sync[0], i_d};

   assign o_q = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 receiver with single-entry valid/ready holding register; define UART_RX_PARITY_EN for 8E1
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_os_tick,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_valid,
   input  logic                 i_rx_ready,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_parity_err
);

   localparam int OW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [OW-1:0] OS_MID  = OW'(OVERSAMPLE / 2 - 1);
   localparam logic [OW-1:0] OS_END  = OW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_END = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
   localparam rx_state_t AFTER_DATA = RX_PARITY;
`else
   localparam rx_state_t AFTER_DATA = RX_STOP;
`endif

   rx_state_t            r_state;
   rx_state_t            w_next;
   logic [OW-1:0]        r_os_cnt;
   logic [BW-1:0]        r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic                 r_parity_err;
   logic                 w_rx_s;
   logic                 w_mid;
   logic                 w_end;
   logic                 w_last;
   logic                 w_par_bad;
   logic                 w_os_clr;
   logic                 w_os_inc;
   logic                 w_go_data;
   logic                 w_shift;
   logic                 w_stop;
   logic                 w_deliver;
   logic                 w_ferr;
   logic                 w_perr;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (w_rx_s)
   );

   // state register
   always_ff @(posedge i_clk)
      if (i_reset) r_state <= RX_IDLE;
      else r_state <= w_next;

   // next state: every transition is qualified by an oversample tick
   always_comb begin
      w_next = r_state;
      if (i_os_tick)
         case (r_state)
            RX_IDLE:      if (!w_rx_s) w_next = RX_START;
            RX_START:     if (w_mid) begin
                             if (w_rx_s) w_next = RX_IDLE;
                             else w_next = RX_DATA;
                          end
            RX_DATA:      if (w_end && w_last) w_next = AFTER_DATA;
            RX_PARITY:    if (w_end) w_next = RX_STOP;
            RX_STOP:      if (w_end) begin
                             if (w_rx_s) w_next = RX_IDLE;
                             else w_next = RX_WAIT_HIGH;
                          end
            RX_WAIT_HIGH: if (w_rx_s) w_next = RX_IDLE;
            default:      w_next = RX_IDLE;
         endcase
   end

   // decoded controls for the counters, shift register and frame result
   always_comb begin
      w_mid     = r_os_cnt == OS_MID;
      w_end     = r_os_cnt == OS_END;
      w_last    = r_bit_cnt == BIT_END;
      w_go_data = i_os_tick && r_state == RX_START && w_mid && !w_rx_s;
      w_os_clr  = i_os_tick && ((r_state == RX_IDLE && !w_rx_s) ||
                                (r_state == RX_START && w_mid) ||
                                (r_state inside {RX_DATA, RX_PARITY, RX_STOP} && w_end));
      w_os_inc  = i_os_tick && r_state inside {RX_START, RX_DATA, RX_PARITY, RX_STOP};
      w_shift   = i_os_tick && r_state == RX_DATA && w_end;
      w_stop    = i_os_tick && r_state == RX_STOP && w_end;
      w_deliver = w_stop && w_rx_s && !w_par_bad;
      w_ferr    = w_stop && !w_rx_s;
      w_perr    = w_stop && w_rx_s && w_par_bad;
   end

`ifdef UART_RX_PARITY_EN
   logic r_par_bad;

   // remember an even-parity mismatch until the stop bit settles the frame
   always_ff @(posedge i_clk)
      if (i_reset || w_go_data) r_par_bad <= 1'b0;
      else if (i_os_tick && r_state == RX_PARITY && w_end) r_par_bad <= w_rx_s ^ (^r_shift);

   assign w_par_bad = r_par_bad;
`else
   assign w_par_bad = 1'b0;
`endif

   // counters, LSB-first shift register, holding register handshake and pulses
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_os_cnt     <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_frame_err  <= 1'b0;
         r_overrun    <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         r_os_cnt  <= w_os_clr ? '0 : w_os_inc ? r_os_cnt + 1'b1 : r_os_cnt;
         r_bit_cnt <= w_go_data ? '0 : w_shift ? r_bit_cnt + 1'b1 : r_bit_cnt;
         if (w_shift) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
         if (w_deliver && (!r_valid || i_rx_ready)) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && i_rx_ready) begin
            r_valid <= 1'b0;
         end
         r_frame_err  <= w_ferr;
         r_overrun    <= w_deliver && r_valid && !i_rx_ready;
         r_parity_err <= w_perr;
      end
   end

   assign o_rx_data    = r_data;
   assign o_rx_valid   = r_valid;
   assign o_frame_err  = r_frame_err;
   assign o_overrun    = r_overrun;
   assign o_parity_err = r_parity_err;

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the hw_uart block: it recovers 8N1 frames (optionally 8E1) from the `rx` line using an externally supplied oversampling tick. Each received byte goes to a single-entry holding register with a valid/ready handshake. It is the receive-side counterpart of the UART transmitter, and the two share the baud generator. Framing errors, overruns and (optionally) parity errors are reported as single-cycle pulses.

## Interface
- `OVERSAMPLE`, default 16: `os_tick` pulses per bit period; even, ≥ 4.
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `os_tick`  in  1  oversample strobe, one `clk` cycle wide, rate = baud × `OVERSAMPLE`.
- `rx`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  `DATA_BITS`  received byte; stable while `rx_valid` = 1.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts; a transfer occurs when `rx_valid` & `rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a frame completed while the holding register was full.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (constant 0 without the parity macro).

## Operation
- `rx` passes through a 2-flop synchronizer whose flops reset to 1. All decisions use the synchronized value `rx_s`.
- The FSM has the states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH. The FSM uses `os_cnt` (log2 `OVERSAMPLE` bits) and `bit_cnt`, and both counters advance only on `os_tick`.
- IDLE: on an `os_tick` with `rx_s` = 0, clear `os_cnt` and go to START.
- START: when `os_cnt` reaches `OVERSAMPLE`/2−1, sample at mid-bit.
  - `rx_s` = 1: false start; return to IDLE with no error.
  - `rx_s` = 0: clear `os_cnt` and `bit_cnt`, go to DATA.
- DATA: every `OVERSAMPLE` ticks, shift `rx_s` into the MSB of the shift register (right shift, so the LSB arrives first). After `DATA_BITS` samples, go to PARITY if the parity macro is defined, otherwise to STOP.
- PARITY: after `OVERSAMPLE` ticks, sample and compare against the even parity of the data. Record a mismatch, then go to STOP.
- STOP: after `OVERSAMPLE` ticks, sample.
  - `rx_s` = 1 and no parity mismatch: deliver the byte and go to IDLE.
  - `rx_s` = 1 with a parity mismatch: pulse `parity_err`, discard the byte, go to IDLE.
  - `rx_s` = 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH (break or misframe).
- WAIT_HIGH: go to IDLE on the first `os_tick` with `rx_s` = 1.
- Deliver:
  - If `rx_valid` = 0 or `rx_ready` = 1 in the same cycle: load `rx_data` and set `rx_valid`.
  - Otherwise: pulse `overrun`, keep the old data, and drop the new byte.
- `rx_valid` clears on the cycle after a transfer, unless a new byte loads in that same cycle, in which case it stays 1.
- Reset values:
  - FSM: IDLE; all counters 0.
  - `rx_data` = 0; `rx_valid`, `frame_err`, `overrun`, `parity_err` = 0.
  - Synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame with no error pulse and also clears a pending `rx_valid`.

## Timing
- Input latency: 2 `clk` cycles through the synchronizer.
- The sample points are `OVERSAMPLE`/2 ticks after the detected falling edge, then every `OVERSAMPLE` ticks. Detection jitter is ≤ 1 tick.
- `rx_valid` rises in the `clk` cycle after the `os_tick` that samples the stop bit. Error pulses occur in that same cycle.
- The receiver is back in IDLE on that same cycle, so back-to-back frames need no extra idle time.
- `rx_ready` is not required while `rx_valid` = 0 and has no effect then.

## Configuration
- `UART_RX_PARITY_EN` defined: frames are 8E1; the PARITY state is active and `parity_err` is live.
- Not defined: frames are 8N1; the PARITY state is never entered and `parity_err` is tied to 0.

## Structure
- The shared package `uart_pkg` holds:
  - the FSM state enum (`rx_state_t`);
  - the default `OVERSAMPLE` and `DATA_BITS` constants, shared with the transmitter and baud generator.
- Sub-module `uart_sync2`: 2-flop synchronizer with a parameterized reset value. It is reusable for other async inputs.

## Test plan
All scenarios use `OVERSAMPLE` = 16 and `os_tick` every cycle (one bit = 16 clk).
- Send 0xA5 8N1 with `rx_ready` = 1 → `rx_valid` pulses once with `rx_data` = 0xA5; no error pulses.
- Send 0x3C then 0xC3 back-to-back, `rx_ready` = 0 until the end → `rx_data` = 0x3C, a single `overrun` pulse, and 0x3C remains after `rx_ready` is raised.
- Send 0x55 with the stop bit forced low, then hold `rx` low for 40 clk → `frame_err` pulses once and `rx_valid` stays 0. A following 0x0F is received correctly.
- Drive a 5-clk low glitch on idle `rx` → the receiver returns to IDLE, with no `rx_valid` and no errors.
- Assert `reset` for 1 cycle during data bit 4 of 0xFF, then send 0x81 → only 0x81 is delivered and all outputs return to their reset values in the interim.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `parity_err` pulses and there is no `rx_valid`. With parity bit 1 → 0x07 is delivered.
